// File: rtl/video_dma_sequencer_pkg.sv
// Shared types and widths for the video DMA sequencer.
package video_dma_sequencer_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BCNT_W = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_e;

endpackage

// File: rtl/video_dma_sequencer_rbuf.sv
// Show-ahead read buffer between the Avalon-MM response
// and the Avalon-ST source; head is valid whenever used != 0.
module video_dma_sequencer_rbuf
  import video_dma_sequencer_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     wrclk,
  input  logic                     wrreset_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   used,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       used_q, used_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    used_d   = used_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge wrclk or negedge wrreset_n) begin
    if (!wrreset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      used_q   <= used_d;
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
      end
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign used  = used_q;
  assign empty = (used_q == '0);

endmodule

// File: rtl/video_dma_sequencer.sv
// Frame-buffer read DMA: bursts a frame from memory into a video stream.
// Optional underrun counter enabled by VIDEO_SEQ_UNDERRUN_CNT_EN.
module video_dma_sequencer
  import video_dma_sequencer_pkg::*;
#(
  parameter int WORDS_PER_FRAME = 153600,
  parameter int BURST_LEN       = 32,
  parameter int RBUF_DEPTH      = 64
) (
  input  logic              wrclk,
  input  logic              wrreset_n,
  input  logic              enable,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              base_wr,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic [BCNT_W-1:0] m_burstcount,
  input  logic              m_waitrequest,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_readdatavalid,
  output logic [DATA_W-1:0] src_data,
  output logic              src_valid,
  output logic              src_sop,
  output logic              src_eop,
  output logic [1:0]        src_empty,
  input  logic              src_ready,
  output logic [15:0]       underrun_count
);

  localparam int WIW = $clog2(WORDS_PER_FRAME + 1);
  localparam int OW  = $clog2(RBUF_DEPTH) + 1;
  localparam int CW  = OW + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              pend_vld_q, pend_vld_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] word_addr_q, word_addr_d;
  logic [ADDR_W-1:0] m_address_q, m_address_d;
  logic              m_read_q, m_read_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIW-1:0]    issued_q, issued_d;
  logic [WIW-1:0]    idx_q, idx_d;
  logic [OW-1:0]     outst_q, outst_d;

  logic [OW-1:0]     rb_used;
  logic              rb_empty;
  logic [DATA_W-1:0] rb_head;
  logic              pop;
  logic              accept;
  logic              last_word;
  logic              eop_acc;
  logic [CW-1:0]     fill;
  logic              credit_ok;

  video_dma_sequencer_rbuf #(
    .DEPTH(RBUF_DEPTH)
  ) u_rbuf (
    .wrclk    (wrclk),
    .wrreset_n(wrreset_n),
    .push     (m_readdatavalid),
    .push_data(m_readdata),
    .pop      (pop),
    .head     (rb_head),
    .used     (rb_used),
    .empty    (rb_empty)
  );

  assign pop       = ~rb_empty & src_ready;
  assign accept    = m_read_q & ~m_waitrequest;
  assign last_word = (idx_q == WIW'(WORDS_PER_FRAME - 1));
  assign eop_acc   = pop & last_word;
  // Buffered plus in-flight words must leave room for a whole burst.
  assign fill      = CW'(rb_used) + CW'(outst_q);
  assign credit_ok = (fill <= CW'(RBUF_DEPTH - BURST_LEN));

  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    pend_vld_d  = pend_vld_q;
    cur_addr_d  = cur_addr_q;
    word_addr_d = word_addr_q;
    m_address_d = m_address_q;
    m_read_d    = m_read_q;
    bcnt_d      = bcnt_q;
    issued_d    = issued_q;
    idx_d       = idx_q;
    done_d      = 1'b0;
    outst_d     = outst_q
                + (accept ? OW'(BURST_LEN) : '0)
                - OW'(m_readdatavalid);
    if (pop) begin
      idx_d = last_word ? '0 : idx_q + WIW'(1);
    end
    if (base_wr) begin
      pend_addr_d = base_addr;
      pend_vld_d  = 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (enable && pend_vld_q) state_d = S_LOAD;
      end
      S_LOAD: begin
        cur_addr_d  = pend_addr_q;
        word_addr_d = pend_addr_q;
        issued_d    = '0;
        pend_vld_d  = base_wr;
        state_d     = S_ISSUE;
      end
      S_ISSUE: begin
        if (m_read_q) begin
          if (!m_waitrequest) begin
            m_read_d    = 1'b0;
            word_addr_d = word_addr_q + ADDR_W'(4 * BURST_LEN);
            issued_d    = issued_q + WIW'(BURST_LEN);
            if (issued_d == WIW'(WORDS_PER_FRAME)) state_d = S_DRAIN;
          end
        end else if (credit_ok) begin
          m_read_d    = 1'b1;
          m_address_d = word_addr_q;
          bcnt_d      = BCNT_W'(BURST_LEN);
        end
      end
      S_DRAIN: begin
        if (eop_acc) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        if (enable && pend_vld_q) begin
          state_d = S_LOAD;
        end else if (enable) begin
          state_d     = S_ISSUE;
          word_addr_d = cur_addr_q;
          issued_d    = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge wrclk or negedge wrreset_n) begin
    if (!wrreset_n) begin
      state_q     <= S_IDLE;
      pend_addr_q <= '0;
      pend_vld_q  <= 1'b0;
      cur_addr_q  <= '0;
      word_addr_q <= '0;
      m_address_q <= '0;
      m_read_q    <= 1'b0;
      bcnt_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      issued_q    <= '0;
      idx_q       <= '0;
      outst_q     <= '0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      pend_vld_q  <= pend_vld_d;
      cur_addr_q  <= cur_addr_d;
      word_addr_q <= word_addr_d;
      m_address_q <= m_address_d;
      m_read_q    <= m_read_d;
      bcnt_q      <= bcnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      issued_q    <= issued_d;
      idx_q       <= idx_d;
      outst_q     <= outst_d;
    end
  end

`ifdef VIDEO_SEQ_UNDERRUN_CNT_EN
  logic [15:0] urun_q, urun_d;

  always_comb begin
    urun_d = urun_q;
    if (state_q == S_LOAD) begin
      urun_d = '0;
    end else if ((state_q == S_ISSUE || state_q == S_DRAIN)
                 && src_ready && rb_empty
                 && urun_q != 16'hFFFF) begin
      urun_d = urun_q + 16'd1;
    end
  end

  always_ff @(posedge wrclk or negedge wrreset_n) begin
    if (!wrreset_n) urun_q <= '0;
    else            urun_q <= urun_d;
  end

  assign underrun_count = urun_q;
`else
  assign underrun_count = '0;
`endif

  assign busy         = busy_q;
  assign frame_done   = done_q;
  assign m_address    = m_address_q;
  assign m_read       = m_read_q;
  assign m_burstcount = bcnt_q;
  assign src_data     = rb_head;
  assign src_valid    = ~rb_empty;
  assign src_sop      = ~rb_empty & (idx_q == '0);
  assign src_eop      = ~rb_empty & last_word;
  assign src_empty    = 2'b00;

endmodule

// File: tb/tb_video_dma_sequencer.sv
// Scoreboard bench: memory model, command/stream checks, frame sequencing.
module tb_video_dma_sequencer;

  localparam int WPF   = 64;
  localparam int BL    = 8;
  localparam int DEPTH = 16;
`ifdef VIDEO_SEQ_UNDERRUN_CNT_EN
  localparam int EXP_UR = 20;
`else
  localparam int EXP_UR = 0;
`endif

  logic        wrclk = 1'b0;
  logic        wrreset_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] base_addr = '0;
  logic        base_wr = 1'b0;
  logic        busy;
  logic        frame_done;
  logic [31:0] m_address;
  logic        m_read;
  logic [6:0]  m_burstcount;
  logic        m_waitrequest = 1'b0;
  logic [31:0] m_readdata = '0;
  logic        m_readdatavalid = 1'b0;
  logic [31:0] src_data;
  logic        src_valid;
  logic        src_sop;
  logic        src_eop;
  logic [1:0]  src_empty;
  logic        src_ready = 1'b1;
  logic [15:0] underrun_count;

  video_dma_sequencer #(
    .WORDS_PER_FRAME(WPF),
    .BURST_LEN      (BL),
    .RBUF_DEPTH     (DEPTH)
  ) dut (
    .wrclk          (wrclk),
    .wrreset_n      (wrreset_n),
    .enable         (enable),
    .base_addr      (base_addr),
    .base_wr        (base_wr),
    .busy           (busy),
    .frame_done     (frame_done),
    .m_address      (m_address),
    .m_read         (m_read),
    .m_burstcount   (m_burstcount),
    .m_waitrequest  (m_waitrequest),
    .m_readdata     (m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .src_data       (src_data),
    .src_valid      (src_valid),
    .src_sop        (src_sop),
    .src_eop        (src_eop),
    .src_empty      (src_empty),
    .src_ready      (src_ready),
    .underrun_count (underrun_count)
  );

  always #5 wrclk = ~wrclk;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] exp_cmd_q[$];
  logic [31:0] mem_q[$];

  int          checks = 0;
  int          failures = 0;
  int          popped = 0;
  int          done_cnt = 0;
  int          cmd_cnt = 0;
  int          wait_cnt = 0;
  logic        mem_stall = 1'b0;
  logic        last_eop = 1'b0;
  logic [31:0] held_addr = '0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [31:0] base);
    beat_t b;
    for (int i = 0; i < WPF; i++) begin
      b.data = base + 32'(4 * i);
      b.sop  = (i == 0);
      b.eop  = (i == WPF - 1);
      exp_q.push_back(b);
    end
    for (int k = 0; k < WPF / BL; k++) begin
      exp_cmd_q.push_back(base + 32'(4 * BL * k));
    end
  endtask

  task automatic strobe_base(input logic [31:0] a);
    @(posedge wrclk); #1;
    base_addr = a;
    base_wr   = 1'b1;
    @(posedge wrclk); #1;
    base_wr   = 1'b0;
  endtask

  task automatic wait_popped(input int target, input int bound);
    int n = 0;
    while (popped < target && n < bound) begin
      @(posedge wrclk);
      n++;
    end
    #1;
    chk("wait_popped", 32'(popped >= target), 32'd1);
  endtask

  task automatic wait_done(input int target, input int bound);
    int n = 0;
    while (done_cnt < target && n < bound) begin
      @(posedge wrclk);
      n++;
    end
    #1;
    chk("wait_done", 32'(done_cnt >= target), 32'd1);
  endtask

  // Memory slave: one-cycle latency, optional stall and waitrequest.
  initial begin
    forever begin
      @(negedge wrclk);
      if (!wrreset_n) begin
        m_readdatavalid = 1'b0;
        m_waitrequest   = 1'b0;
        mem_q.delete();
      end else begin
        if (!mem_stall && mem_q.size() > 0) begin
          m_readdatavalid = 1'b1;
          m_readdata      = mem_q.pop_front();
        end else begin
          m_readdatavalid = 1'b0;
          m_readdata      = '0;
        end
        if (m_read && cmd_cnt == 2 && wait_cnt < 5) begin
          if (wait_cnt == 0) begin
            held_addr = m_address;
          end else begin
            chk("hold_addr", m_address, held_addr);
            chk("hold_bcnt", 32'(m_burstcount), 32'(BL));
          end
          m_waitrequest = 1'b1;
          wait_cnt++;
        end else if (m_read) begin
          m_waitrequest = 1'b0;
          if (cmd_cnt == 2) chk("hold_accept", m_address, held_addr);
          cmd_cnt++;
          if (exp_cmd_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL cmd_unexpected actual=%h expected=none",
                     m_address);
          end else begin
            chk("cmd_addr", m_address, exp_cmd_q.pop_front());
          end
          chk("cmd_bcnt", 32'(m_burstcount), 32'(BL));
          for (int i = 0; i < BL; i++) begin
            mem_q.push_back(m_address + 32'(4 * i));
          end
          chk("outstanding_max", 32'(mem_q.size() <= DEPTH), 32'd1);
        end else begin
          m_waitrequest = 1'b0;
        end
      end
    end
  end

  // Stream monitor: pops the scoreboard on every accepted beat.
  initial begin
    beat_t e;
    forever begin
      @(negedge wrclk);
      if (wrreset_n && src_valid && src_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL beat_unexpected actual=%h expected=none",
                   src_data);
        end else begin
          e = exp_q.pop_front();
          chk("src_data", src_data, e.data);
          chk("src_sop", 32'(src_sop), 32'(e.sop));
          chk("src_eop", 32'(src_eop), 32'(e.eop));
        end
        chk("src_empty", 32'(src_empty), 32'd0);
        popped++;
        last_eop = src_eop;
      end
      if (wrreset_n && frame_done) begin
        done_cnt++;
        chk("done_after_eop", 32'(last_eop), 32'd1);
        last_eop = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] u0;
    int          d;
    repeat (3) @(posedge wrclk);
    @(negedge wrclk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_m_read", 32'(m_read), 32'd0);
    chk("rst_src_valid", 32'(src_valid), 32'd0);
    chk("rst_sop", 32'(src_sop), 32'd0);
    chk("rst_eop", 32'(src_eop), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_m_address", m_address, 32'd0);
    chk("rst_underrun", 32'(underrun_count), 32'd0);
    @(posedge wrclk); #1;
    wrreset_n = 1'b1;

    push_frame(32'h1000);
    enable = 1'b1;
    strobe_base(32'h1000);
    wait_popped(10, 2000);
    chk("busy_run", 32'(busy), 32'd1);
    enable = 1'b0;
    wait_done(1, 2000);
    repeat (3) @(negedge wrclk);
    chk("idle_busy_f1", 32'(busy), 32'd0);
    chk("done_cnt_f1", 32'(done_cnt), 32'd1);
    chk("wait_cycles", 32'(wait_cnt), 32'd5);

    push_frame(32'h2000);
    push_frame(32'h8000);
    push_frame(32'h8000);
    enable = 1'b1;
    strobe_base(32'h2000);
    wait_popped(84, 2000);
    strobe_base(32'h8000);
    wait_popped(94, 2000);
    src_ready = 1'b0;
    repeat (200) @(posedge wrclk);
    #1;
    src_ready = 1'b1;

    wait_popped(140, 2000);
    mem_stall = 1'b1;
    repeat (30) @(negedge wrclk);
    u0 = underrun_count;
    repeat (20) @(negedge wrclk);
    d = int'(underrun_count) - int'(u0);
    chk("underrun_delta", 32'(d), 32'(EXP_UR));
    @(posedge wrclk); #1;
    mem_stall = 1'b0;

    wait_popped(202, 3000);
    enable = 1'b0;
    wait_done(4, 3000);
    repeat (5) @(negedge wrclk);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_m_read", 32'(m_read), 32'd0);
    chk("end_src_valid", 32'(src_valid), 32'd0);
    chk("end_done_cnt", 32'(done_cnt), 32'd4);
    chk("end_popped", 32'(popped), 32'(4 * WPF));
    chk("end_beats_left", 32'(exp_q.size()), 32'd0);
    chk("end_cmds_left", 32'(exp_cmd_q.size()), 32'd0);
    chk("end_cmd_total", 32'(cmd_cnt), 32'(4 * WPF / BL));
    chk("end_mem_left", 32'(mem_q.size()), 32'd0);
`ifndef VIDEO_SEQ_UNDERRUN_CNT_EN
    chk("underrun_zero", 32'(underrun_count), 32'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
